// File: rtl/varint_field_writer.sv
`default_nettype none
// ============================================================================
// Module      : varint_field_writer
// Description : Serialises one protobuf varint field into DRAM through a
//               LANES-wide byte-lane write port. The field is encoded once at
//               accept into a 15-byte buffer, then streamed as one or more
//               beats, each held until dram_ack.
//               Optional feature macro: VARINT_TAG_EN. When it is defined,
//               the key varint (field_num<<3 | 0) is emitted ahead of the value.
// Revision    : 1.0 - initial release
// ============================================================================
module varint_field_writer #(
    parameter int LANES  = 8,
    parameter int ADDR_W = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         dst_addr,
    input  logic [63:0]               value,
    input  logic [4:0]                field_type,
    input  logic [28:0]               field_num,
    output logic                      busy,
    output logic [LANES-1:0]          dram_en,
    output logic [LANES*ADDR_W-1:0]   dram_addr,
    output logic [LANES*8-1:0]        dram_data,
    output logic                      dram_rdwr,
    input  logic                      dram_ack,
    output logic                      done,
    output logic [3:0]                bytes_written
);

    // Buffer is 16 bytes wide so that one beat of up to 16 lanes can always be
    // sliced from it; only 15 bytes are ever populated.
    localparam int BUF_W = 128;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BEAT = 1'b1
    } state_t;

    state_t                    state_q;
    logic [BUF_W-1:0]          buf_q;
    logic [3:0]                n_q;
    logic [ADDR_W-1:0]         base_q;
    logic [3:0]                beat_q;
    logic                      busy_q;
    logic                      done_q;
    logic [3:0]                bw_q;
    logic [LANES-1:0]          en_q;
    logic [LANES*ADDR_W-1:0]   addr_q;
    logic [LANES*8-1:0]        data_q;

    // Encoder signals
    logic [63:0]               enc_val;
    logic [69:0]               val_ext;
    logic [3:0]                val_len;
    logic [79:0]               val_bytes;
    logic [2:0]                tag_len;
    logic [39:0]               tag_bytes;
    logic [BUF_W-1:0]          enc_buf;
    logic [3:0]                enc_n;

    // Beat generation signals
    logic [BUF_W-1:0]          sel_buf;
    logic [ADDR_W-1:0]         sel_base;
    logic [3:0]                sel_n;
    logic [3:0]                sel_beat;
    logic [8:0]                first_j;
    logic [8:0]                lane_j;
    logic [BUF_W-1:0]          beat_bytes;
    logic                      last_beat;
    logic [LANES-1:0]          lane_en_d;
    logic [LANES*ADDR_W-1:0]   lane_addr_d;
    logic [LANES*8-1:0]        lane_data_d;

    // Map the raw value to the 64-bit quantity that is varint-encoded.
    always_comb begin
        case (field_type)
            5'd5:    enc_val = {{32{value[31]}}, value[31:0]};
            5'd17:   enc_val = {32'd0, {value[30:0], 1'b0} ^ {32{value[31]}}};
            5'd18:   enc_val = {value[62:0], 1'b0} ^ {64{value[63]}};
            default: enc_val = value;
        endcase
    end

    assign val_ext = {6'd0, enc_val};

    // Value length is one more than the highest non-empty 7-bit group (min 1),
    // and every byte but the last carries the continuation bit.
    always_comb begin
        val_len = 4'd1;
        for (int b = 1; b < 10; b++) begin
            if (val_ext[7*b +: 7] != 7'd0) begin
                val_len = 4'(b + 1);
            end
        end
        val_bytes = '0;
        for (int b = 0; b < 10; b++) begin
            val_bytes[8*b +: 8] = {(4'(b) < (val_len - 4'd1)), val_ext[7*b +: 7]};
        end
    end

`ifdef VARINT_TAG_EN
    logic [34:0] key_ext;

    assign key_ext = {3'd0, field_num, 3'b000};

    // Key varint (wire type 0) encoded the same way as the value, 1..5 bytes.
    always_comb begin
        tag_len = 3'd1;
        for (int b = 1; b < 5; b++) begin
            if (key_ext[7*b +: 7] != 7'd0) begin
                tag_len = 3'(b + 1);
            end
        end
        tag_bytes = '0;
        for (int b = 0; b < 5; b++) begin
            tag_bytes[8*b +: 8] = {(3'(b) < (tag_len - 3'd1)), key_ext[7*b +: 7]};
        end
    end
`else
    logic unused_field_num;

    assign unused_field_num = ^field_num;
    assign tag_len          = 3'd0;
    assign tag_bytes        = 40'd0;
`endif

    // Value bytes are placed directly after the tag bytes.
    assign enc_buf = {88'd0, tag_bytes} | ({48'd0, val_bytes} << {tag_len, 3'b000});
    assign enc_n   = {1'b0, tag_len} + val_len;

    // Choose the beat being prepared: beat 0 of a fresh request while idle,
    // otherwise the beat that follows the one currently presented.
    always_comb begin
        if (state_q == IDLE) begin
            sel_buf  = enc_buf;
            sel_base = dst_addr;
            sel_n    = enc_n;
            sel_beat = 4'd0;
        end else begin
            sel_buf  = buf_q;
            sel_base = base_q;
            sel_n    = n_q;
            sel_beat = beat_q + 4'd1;
        end
    end

    assign first_j    = 9'(sel_beat) * 9'(LANES);
    assign beat_bytes = sel_buf >> {first_j, 3'b000};
    assign last_beat  = (first_j >= {5'd0, n_q});

    // Per-lane enable, wrapping address and gated data for the selected beat.
    always_comb begin
        lane_en_d   = '0;
        lane_addr_d = '0;
        lane_data_d = '0;
        lane_j      = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_j                        = first_j + 9'(i);
            lane_en_d[i]                  = (lane_j < {5'd0, sel_n});
            lane_addr_d[i*ADDR_W +: ADDR_W] = sel_base + ADDR_W'(lane_j);
            lane_data_d[i*8 +: 8]         = lane_en_d[i] ? beat_bytes[i*8 +: 8] : 8'd0;
        end
    end

    // Control FSM with registered DRAM-side outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            n_q     <= 4'd0;
            base_q  <= '0;
            beat_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bw_q    <= 4'd0;
            en_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        buf_q   <= enc_buf;
                        n_q     <= enc_n;
                        base_q  <= dst_addr;
                        beat_q  <= 4'd0;
                        busy_q  <= 1'b1;
                        en_q    <= lane_en_d;
                        addr_q  <= lane_addr_d;
                        data_q  <= lane_data_d;
                        state_q <= BEAT;
                    end
                end
                BEAT: begin
                    if (dram_ack) begin
                        if (last_beat) begin
                            en_q    <= '0;
                            addr_q  <= '0;
                            data_q  <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            bw_q    <= n_q;
                            state_q <= IDLE;
                        end else begin
                            beat_q <= beat_q + 4'd1;
                            en_q   <= lane_en_d;
                            addr_q <= lane_addr_d;
                            data_q <= lane_data_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign dram_rdwr     = busy_q;
    assign dram_en       = en_q;
    assign dram_addr     = addr_q;
    assign dram_data     = data_q;
    assign done          = done_q;
    assign bytes_written = bw_q;

endmodule
`default_nettype wire

// File: tb/tb_varint_field_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_varint_field_writer
// Description : Self-checking bench for varint_field_writer (LANES=8,
//               ADDR_W=64). A transaction-level model encodes each request
//               arithmetically and predicts the beat stream; a per-cycle
//               compare process checks the DUT against it, and directed
//               literal checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_varint_field_writer;

    localparam int LANES = 8;
    localparam int AW    = 64;

    logic                  clk;
    logic                  reset_n;
    logic                  start;
    logic [AW-1:0]         dst_addr;
    logic [63:0]           value;
    logic [4:0]            field_type;
    logic [28:0]           field_num;
    logic                  busy;
    logic [LANES-1:0]      dram_en;
    logic [LANES*AW-1:0]   dram_addr;
    logic [LANES*8-1:0]    dram_data;
    logic                  dram_rdwr;
    logic                  dram_ack;
    logic                  done;
    logic [3:0]            bytes_written;

    int n_tot  = 0;
    int n_pass = 0;

    varint_field_writer #(.LANES(LANES), .ADDR_W(AW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .dst_addr      (dst_addr),
        .value         (value),
        .field_type    (field_type),
        .field_num     (field_num),
        .busy          (busy),
        .dram_en       (dram_en),
        .dram_addr     (dram_addr),
        .dram_data     (dram_data),
        .dram_rdwr     (dram_rdwr),
        .dram_ack      (dram_ack),
        .done          (done),
        .bytes_written (bytes_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_buf [16];
    int          m_n    = 0;
    int          m_beat = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [3:0]  m_bw   = 4'd0;
    logic [63:0] m_base = 64'd0;

    function automatic logic [63:0] map_val(input logic [63:0] v, input logic [4:0] t);
        longint s;
        int     s32;
        case (t)
            5'd5: begin
                s32 = int'(v[31:0]);
                s   = longint'(s32);
                return s;
            end
            5'd17: begin
                s32 = int'(v[31:0]);
                s   = longint'(s32);
                if (s >= 0) return 64'(2 * s);
                else        return 64'(-2 * s - 1);
            end
            5'd18: begin
                s = longint'(v);
                if (s >= 0) return 64'(2 * s);
                else        return 64'(-2 * s - 1);
            end
            default: return v;
        endcase
    endfunction

    function automatic void push_varint(input logic [63:0] v);
        logic [63:0] x;
        logic [7:0]  b;
        x = v;
        do begin
            b = 8'(x % 64'd128);
            x = x / 64'd128;
            if (x != 64'd0) b = b + 8'd128;
            m_buf[m_n] = b;
            m_n++;
        end while (x != 64'd0);
    endfunction

    function automatic void model_accept(input logic [63:0] v, input logic [4:0] t,
                                         input logic [28:0] fn);
        m_n = 0;
`ifdef VARINT_TAG_EN
        push_varint(64'(fn) * 64'd8);
`else
        if (fn == 29'd0) m_n = 0;
`endif
        push_varint(map_val(v, t));
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_bw   = 4'd0;
            m_beat = 0;
            m_n    = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    model_accept(value, field_type, field_num);
                    m_base = dst_addr;
                    m_beat = 0;
                    m_busy = 1'b1;
                end
            end else if (dram_ack) begin
                if (m_beat == (m_n + LANES - 1) / LANES - 1) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_bw   = 4'(m_n);
                end else begin
                    m_beat++;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [LANES-1:0]    e_en;
        logic [LANES*AW-1:0] e_addr;
        logic [LANES*8-1:0]  e_data;
        int j;
        e_en   = '0;
        e_addr = '0;
        e_data = '0;
        for (int i = 0; i < LANES; i++) begin
            j = m_beat * LANES + i;
            e_addr[i*AW +: AW] = m_base + 64'(j);
            if (m_busy && j < m_n) begin
                e_en[i]           = 1'b1;
                e_data[i*8 +: 8]  = m_buf[j];
            end
        end
        chk("busy", busy, m_busy);
        chk("rdwr", dram_rdwr, m_busy);
        chk("en", dram_en, e_en);
        chk("done", done, m_done);
        chk("bytes_written", bytes_written, m_bw);
        if (m_busy) begin
            chk("addr", dram_addr, e_addr);
            chk("data", dram_data, e_data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [63:0] a, input logic [63:0] v,
                         input logic [4:0] t, input logic [28:0] fn);
        dst_addr   = a;
        value      = v;
        field_type = t;
        field_num  = fn;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        dst_addr   = 64'hDEAD_BEEF_0000_0000;
        value      = ~v;
        field_type = 5'd18;
        field_num  = 29'h1ABCDEF;
    endtask

    task automatic wait_done(input int bound);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < bound && !seen; c++) begin
            dram_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("done_timeout", seen, 1'b1);
    endtask

    logic [63:0] sweep_v [6] = '{64'h7F, 64'h80, 64'h8000_0000_0000_0000,
                                 64'h8000_0000, 64'h8000_0000, 64'h8000_0000_0000_0000};
    logic [4:0]  sweep_t [6] = '{5'd0, 5'd13, 5'd4, 5'd5, 5'd17, 5'd18};

    initial begin
        logic [LANES-1:0]    s_en;
        logic [LANES*AW-1:0] s_addr;
        logic [LANES*8-1:0]  s_data;

        reset_n    = 1'b0;
        start      = 1'b0;
        dram_ack   = 1'b0;
        dst_addr   = '0;
        value      = '0;
        field_type = '0;
        field_num  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_en", dram_en, 8'h00);
        chk("rst_addr", dram_addr, '0);
        chk("rst_data", dram_data, '0);
        chk("rst_rdwr", dram_rdwr, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_bw", bytes_written, 4'd0);

        reset_n  = 1'b1;
        dram_ack = 1'b1;
        @(negedge clk);
        chk("idle_ack_busy", busy, 1'b0);

        // zero value -> single 0x00 byte
        issue(64'h40, 64'd0, 5'd13, 29'd0);
`ifndef VARINT_TAG_EN
        chk("t1_en", dram_en, 8'h01);
        chk("t1_data", dram_data[7:0], 8'h00);
        chk("t1_addr", dram_addr[63:0], 64'h40);
`endif
        @(negedge clk);
        chk("t1_done", done, 1'b1);
`ifndef VARINT_TAG_EN
        chk("t1_bw", bytes_written, 4'd1);
`endif

        // 300 -> AC 02
        issue(64'h1000, 64'd300, 5'd3, 29'd0);
`ifndef VARINT_TAG_EN
        chk("t2_en", dram_en, 8'h03);
        chk("t2_data", dram_data[15:0], 16'h02AC);
        chk("t2_addr1", dram_addr[127:64], 64'h1001);
`endif
        @(negedge clk);
`ifndef VARINT_TAG_EN
        chk("t2_bw", bytes_written, 4'd2);
`endif

        // int32 -1 -> ten bytes over two beats
        dram_ack = 1'b0;
        issue(64'h2000, 64'h0000_0000_FFFF_FFFF, 5'd5, 29'd0);
`ifndef VARINT_TAG_EN
        chk("t3_en0", dram_en, 8'hFF);
        chk("t3_data0", dram_data, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
        dram_ack = 1'b1;
        @(negedge clk);
`ifndef VARINT_TAG_EN
        chk("t3_en1", dram_en, 8'h03);
        chk("t3_data1", dram_data[15:0], 16'h01FF);
        chk("t3_addr1", dram_addr[63:0], 64'h2008);
`endif
        @(negedge clk);
        chk("t3_done", done, 1'b1);
`ifndef VARINT_TAG_EN
        chk("t3_bw", bytes_written, 4'd10);
`endif

        // back-to-back: start in the done cycle, sint32 -2 -> 0x03
        issue(64'h3000, 64'hFFFF_FFFF_FFFF_FFFE, 5'd17, 29'd0);
        chk("t4_busy", busy, 1'b1);
`ifndef VARINT_TAG_EN
        chk("t4_bw_held", bytes_written, 4'd10);
        chk("t4_en", dram_en, 8'h01);
        chk("t4_data", dram_data[7:0], 8'h03);
`endif
        @(negedge clk);
`ifndef VARINT_TAG_EN
        chk("t4_bw", bytes_written, 4'd1);
`endif
        // sint64 1 -> 0x02
        issue(64'h3100, 64'd1, 5'd18, 29'd0);
`ifndef VARINT_TAG_EN
        chk("t4b_data", dram_data[7:0], 8'h02);
`endif
        @(negedge clk);

        // field 1, value 150
        issue(64'h4000, 64'd150, 5'd0, 29'd1);
`ifdef VARINT_TAG_EN
        chk("t5_en", dram_en, 8'h07);
        chk("t5_data", dram_data[23:0], 24'h019608);
`else
        chk("t5_en", dram_en, 8'h03);
        chk("t5_data", dram_data[15:0], 16'h0196);
`endif
        @(negedge clk);
`ifdef VARINT_TAG_EN
        chk("t5_bw", bytes_written, 4'd3);
`endif

        // address wrap at 2^64
        issue(64'hFFFF_FFFF_FFFF_FFFE, 64'd16384, 5'd3, 29'd0);
`ifndef VARINT_TAG_EN
        chk("wrap_data", dram_data[23:0], 24'h018080);
        chk("wrap_addr2", dram_addr[191:128], 64'h0);
`endif
        @(negedge clk);

        // ack held low: outputs stable, start while busy ignored, then reset
        dram_ack = 1'b0;
        issue(64'h5000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 29'd0);
        s_en   = dram_en;
        s_addr = dram_addr;
        s_data = dram_data;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                start    = 1'b1;
                dst_addr = 64'h9000;
                value    = 64'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            chk("hold_en", dram_en, s_en);
            chk("hold_addr", dram_addr, s_addr);
            chk("hold_data", dram_data, s_data);
        end
        start    = 1'b0;
        dram_ack = 1'b1;
        @(negedge clk);
        dram_ack = 1'b0;
`ifndef VARINT_TAG_EN
        chk("hold_en1", dram_en, 8'h03);
`endif
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_en", dram_en, 8'h00);
        chk("mid_rst_addr", dram_addr, '0);
        chk("mid_rst_data", dram_data, '0);
        chk("mid_rst_rdwr", dram_rdwr, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        @(negedge clk);
        chk("mid_rst_nodone", done, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        // model-checked sweep with random ack
        for (int t = 0; t < 6; t++) begin
            issue(64'h6000 + 64'(t * 32), sweep_v[t], sweep_t[t], 29'(t * 1000));
            wait_done(60);
        end
        dram_ack = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
